// File: rtl/quad_encoder_mc.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_mc
//  Description : Multi-channel A/B/Z incremental encoder decoder. Each pin is
//                synchronised and glitch-filtered. Each channel decodes x4
//                quadrature into a signed position, captures the position on
//                index rising edges (optionally zeroing it) and keeps a
//                sticky flag for illegal (double-bit) transitions.
//  Ports       : I_CLK_100MHZ  clock, rising edge
//                I_RST         asynchronous active-high reset
//                I_ENC_A/B/Z   raw encoder pins, bit i = channel i
//                I_Z_CLR_EN    index rising edge zeroes the position
//                I_DIR_INV     swap count direction
//                I_CNT_CLR     level-sensitive clear of pos/z_pos/err
//                O_POS         position, channel i at [i*CNT_W +: CNT_W]
//                O_Z_POS       position captured at the last index edge
//                O_Z_VLD       1-cycle pulse when O_Z_POS updates
//                O_STEP        1-cycle pulse per accepted count
//                O_DIR         direction of the last count, 1 = up
//                O_ERR         sticky illegal-transition flag
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_mc #(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8
) (
    input  logic                    I_CLK_100MHZ,
    input  logic                    I_RST,
    input  logic [N_CH-1:0]         I_ENC_A,
    input  logic [N_CH-1:0]         I_ENC_B,
    input  logic [N_CH-1:0]         I_ENC_Z,
    input  logic [N_CH-1:0]         I_Z_CLR_EN,
    input  logic [N_CH-1:0]         I_DIR_INV,
    input  logic [N_CH-1:0]         I_CNT_CLR,
    output logic [N_CH*CNT_W-1:0]   O_POS,
    output logic [N_CH*CNT_W-1:0]   O_Z_POS,
    output logic [N_CH-1:0]         O_Z_VLD,
    output logic [N_CH-1:0]         O_STEP,
    output logic [N_CH-1:0]         O_DIR,
    output logic [N_CH-1:0]         O_ERR
);

    localparam int                c_N_PIN       = 3 * N_CH;
    localparam int                c_FW          = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_FW-1:0]   c_FILT_MAX    = c_FW'(FILT_LEN - 1);
    localparam int                c_SW          = $clog2(SYNC_STAGES + 1);
    localparam logic [c_SW-1:0]   c_SETTLE_DONE = c_SW'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  c_ONE         = {{(CNT_W-1){1'b0}}, 1'b1};

    // Pin p: A of ch at p = ch, B at N_CH + ch, Z at 2*N_CH + ch.
    logic [c_N_PIN-1:0] w_raw;
    logic [c_N_PIN-1:0] w_filt;
    logic [c_N_PIN-1:0] w_idle;

    assign w_raw = {I_ENC_Z, I_ENC_B, I_ENC_A};

    // Right after reset the sync chains still hold their reset zeros, which
    // look like genuine idle pins. Arming is held off until the chains carry
    // sampled pin levels, otherwise pins parked at 1 would later appear as a
    // double-bit transition.
    logic [c_SW-1:0] r_settle;
    logic            w_settled;

    assign w_settled = (r_settle == c_SETTLE_DONE);

    always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
        if (I_RST) begin
            r_settle <= '0;
        end else if (!w_settled) begin
            r_settle <= r_settle + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-pin synchroniser and persistence filter
    // ------------------------------------------------------------------
    for (genvar p = 0; p < c_N_PIN; p++) begin : g_pin
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_FW-1:0]        r_cnt;
        logic                   r_filt;
        logic                   w_differ;

        assign w_differ = r_sync[SYNC_STAGES-1] ^ r_filt;

        always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
            if (I_RST) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_filt <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[p]};
                if (!w_differ) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_FILT_MAX) begin
                    r_filt <= ~r_filt;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_filt[p] = r_filt;
        // Idle means nothing in flight: counter at rest and level agrees.
        assign w_idle[p] = (r_cnt == '0) && !w_differ;
    end

    // ------------------------------------------------------------------
    // Per-channel decoder, counter and index capture
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [1:0]       r_prev_ab;
        logic             r_prev_z;
        logic             r_armed;
        logic [CNT_W-1:0] r_pos;
        logic [CNT_W-1:0] r_z_pos;
        logic             r_z_vld;
        logic             r_step;
        logic             r_dir;
        logic             r_err;

        logic [1:0]       w_cur_ab;
        logic             w_cur_z;
        logic             w_arm_ok;
        logic [1:0]       w_ph_prev;
        logic [1:0]       w_ph_cur;
        logic [1:0]       w_ph_diff;
        logic             w_step;
        logic             w_bad;
        logic             w_up;
        logic             w_z_rise;
        logic             w_z_clear;
        logic [CNT_W-1:0] w_pos_step;
        logic [CNT_W-1:0] w_pos_d;
        logic [CNT_W-1:0] w_z_pos_d;
        logic             w_dir_d;
        logic             w_err_d;

        assign w_cur_ab = {w_filt[ch], w_filt[N_CH + ch]};
        assign w_cur_z  = w_filt[2*N_CH + ch];
        assign w_arm_ok = w_settled && w_idle[ch] && w_idle[N_CH + ch] &&
                          w_idle[2*N_CH + ch];

        // {A,B} mapped to a 2-bit phase counting 0,1,2,3 along the up
        // sequence 00->10->11->01: phase = {B, A^B}. The phase difference
        // is 1 for up, 3 for down and 2 for an illegal double change.
        assign w_ph_prev  = {r_prev_ab[0], ^r_prev_ab};
        assign w_ph_cur   = {w_cur_ab[0], ^w_cur_ab};
        assign w_ph_diff  = w_ph_cur - w_ph_prev;
        assign w_step     = r_armed && w_ph_diff[0];
        assign w_bad      = r_armed && (w_ph_diff == 2'd2);
        assign w_up       = (w_ph_diff == 2'd1) ^ I_DIR_INV[ch];
        assign w_z_rise   = r_armed && !r_prev_z && w_cur_z;
        assign w_z_clear  = w_z_rise && I_Z_CLR_EN[ch];

        assign w_pos_step = !w_step ? r_pos :
                            (w_up ? r_pos + c_ONE : r_pos - c_ONE);

        // Clear beats index-zeroing, which beats the step itself.
        assign w_pos_d    = (I_CNT_CLR[ch] || w_z_clear) ? '0 : w_pos_step;
        assign w_z_pos_d  = I_CNT_CLR[ch] ? '0 :
                            (w_z_rise ? w_pos_step : r_z_pos);
        assign w_dir_d    = w_step ? w_up : r_dir;
        assign w_err_d    = I_CNT_CLR[ch] ? 1'b0 : (r_err | w_bad);

        always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
            if (I_RST) begin
                r_prev_ab <= 2'b00;
                r_prev_z  <= 1'b0;
                r_armed   <= 1'b0;
                r_pos     <= '0;
                r_z_pos   <= '0;
                r_z_vld   <= 1'b0;
                r_step    <= 1'b0;
                r_dir     <= 1'b0;
                r_err     <= 1'b0;
            end else begin
                // Tracking the filtered levels every cycle also performs the
                // load on the arming cycle; events are gated by r_armed.
                r_prev_ab <= w_cur_ab;
                r_prev_z  <= w_cur_z;
                if (w_arm_ok) begin
                    r_armed <= 1'b1;
                end
                r_pos     <= w_pos_d;
                r_z_pos   <= w_z_pos_d;
                r_z_vld   <= w_z_rise;
                r_step    <= w_step;
                r_dir     <= w_dir_d;
                r_err     <= w_err_d;
            end
        end

        assign O_POS[ch*CNT_W +: CNT_W]   = r_pos;
        assign O_Z_POS[ch*CNT_W +: CNT_W] = r_z_pos;
        assign O_Z_VLD[ch]                = r_z_vld;
        assign O_STEP[ch]                 = r_step;
        assign O_DIR[ch]                  = r_dir;
        assign O_ERR[ch]                  = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quad_encoder_mc
//  Description : Self-checking bench for quad_encoder_mc with a window-based
//                behavioural model compared every cycle, plus directed
//                literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_mc;

    localparam int NC = 2;
    localparam int W  = 16;
    localparam int S  = 2;
    localparam int F  = 4;
    localparam int HL = S + F;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NC-1:0]     enc_a = '0, enc_b = '0, enc_z = '0;
    logic [NC-1:0]     z_clr_en = '0, dir_inv = '0, cnt_clr = '0;
    logic [NC*W-1:0]   pos, zpos;
    logic [NC-1:0]     zvld, step, dir, err;

    always #5 clk = ~clk;

    quad_encoder_mc #(.N_CH(NC), .CNT_W(W), .SYNC_STAGES(S), .FILT_LEN(F)) dut (
        .I_CLK_100MHZ (clk),
        .I_RST        (rst),
        .I_ENC_A      (enc_a),
        .I_ENC_B      (enc_b),
        .I_ENC_Z      (enc_z),
        .I_Z_CLR_EN   (z_clr_en),
        .I_DIR_INV    (dir_inv),
        .I_CNT_CLR    (cnt_clr),
        .O_POS        (pos),
        .O_Z_POS      (zpos),
        .O_Z_VLD      (zvld),
        .O_STEP       (step),
        .O_DIR        (dir),
        .O_ERR        (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Next {A,B} along the up sequence 00->10->11->01->00.
    function automatic logic [1:0] up_next(input logic [1:0] s);
        case (s)
            2'b00:   up_next = 2'b10;
            2'b10:   up_next = 2'b11;
            2'b11:   up_next = 2'b01;
            default: up_next = 2'b00;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // hist bit 0 = pin level captured at this edge. A filtered level flips
    // once the F samples that have crossed the synchroniser all disagree.
    logic [HL-1:0] ha [NC], hb [NC], hz [NC];
    bit            fa [NC], fb [NC], fz [NC];
    bit            pa [NC], pb [NC], pz [NC];
    bit            m_armed [NC];
    logic [W-1:0]  m_pos [NC], m_zpos [NC];
    bit            m_zvld [NC], m_step [NC], m_dir [NC], m_err [NC];
    int            since_rst = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            since_rst = 0;
            for (int c = 0; c < NC; c++) begin
                ha[c] = '0; hb[c] = '0; hz[c] = '0;
                fa[c] = 0; fb[c] = 0; fz[c] = 0; pa[c] = 0; pb[c] = 0; pz[c] = 0;
                m_armed[c] = 0; m_pos[c] = '0; m_zpos[c] = '0;
                m_zvld[c] = 0; m_step[c] = 0; m_dir[c] = 0; m_err[c] = 0;
            end
        end else begin
            if (since_rst < 1000) since_rst++;
            for (int c = 0; c < NC; c++) begin
                logic [1:0]   pab, cab;
                logic [W-1:0] nxt;
                bit           legal, fwd, upd;
                m_step[c] = 0;
                m_zvld[c] = 0;
                pab = {pa[c], pb[c]};
                cab = {fa[c], fb[c]};
                if (m_armed[c]) begin
                    legal = 0; fwd = 0;
                    if (cab == up_next(pab)) begin legal = 1; fwd = 1; end
                    else if (pab == up_next(cab)) legal = 1;
                    else if (cab != pab) m_err[c] = 1;
                    nxt = m_pos[c];
                    if (legal) begin
                        upd = fwd ^ dir_inv[c];
                        nxt = upd ? nxt + 1'b1 : nxt - 1'b1;
                        m_step[c] = 1;
                        m_dir[c]  = upd;
                    end
                    m_pos[c] = nxt;
                    if (!pz[c] && fz[c]) begin
                        m_zpos[c] = nxt;
                        m_zvld[c] = 1;
                        if (z_clr_en[c]) m_pos[c] = '0;
                    end
                end
                if (cnt_clr[c]) begin
                    m_pos[c] = '0; m_err[c] = 0; m_zpos[c] = '0;
                end
                pa[c] = fa[c]; pb[c] = fb[c]; pz[c] = fz[c];
                ha[c] = {ha[c][HL-2:0], enc_a[c]};
                hb[c] = {hb[c][HL-2:0], enc_b[c]};
                hz[c] = {hz[c][HL-2:0], enc_z[c]};
                if (ha[c][HL-1:S] == {F{~fa[c]}}) fa[c] = ~fa[c];
                if (hb[c][HL-1:S] == {F{~fb[c]}}) fb[c] = ~fb[c];
                if (hz[c][HL-1:S] == {F{~fz[c]}}) fz[c] = ~fz[c];
                if (!m_armed[c] && since_rst >= HL + 2 &&
                    ha[c] == {HL{fa[c]}} && hb[c] == {HL{fb[c]}} && hz[c] == {HL{fz[c]}})
                    m_armed[c] = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("pos ch%0d", c),  32'(pos[c*W +: W]),  rst ? 32'd0 : 32'(m_pos[c]));
            check($sformatf("zpos ch%0d", c), 32'(zpos[c*W +: W]), rst ? 32'd0 : 32'(m_zpos[c]));
            check($sformatf("zvld ch%0d", c), 32'(zvld[c]), rst ? 32'd0 : 32'(m_zvld[c]));
            check($sformatf("step ch%0d", c), 32'(step[c]), rst ? 32'd0 : 32'(m_step[c]));
            check($sformatf("dir ch%0d", c),  32'(dir[c]),  rst ? 32'd0 : 32'(m_dir[c]));
            check($sformatf("err ch%0d", c),  32'(err[c]),  rst ? 32'd0 : 32'(m_err[c]));
        end
    end

    // Pulse counters for channel 0.
    int steps0 = 0;
    int zvlds0 = 0;
    initial forever begin
        @(negedge clk);
        if (step[0]) steps0++;
        if (zvld[0]) zvlds0++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_ab(input int c, input logic [1:0] ab);
        @(posedge clk); #1;
        enc_a[c] = ab[1];
        enc_b[c] = ab[0];
        hold(9);
    endtask

    task automatic up_edges(input int c, input int n);
        for (int i = 0; i < n; i++) set_ab(c, up_next({enc_a[c], enc_b[c]}));
    endtask

    task automatic pulse_clr(input int c);
        @(posedge clk); #1 cnt_clr[c] = 1'b1;
        @(posedge clk); #1 cnt_clr[c] = 1'b0;
    endtask

    initial begin : main
        int s0;
        hold(3);
        #1 rst = 1'b0;
        hold(20);
        @(negedge clk);
        check("reset pos0", 32'(pos[0 +: W]), 32'd0);
        check("reset err",  32'(err), 32'd0);

        // Forward: 16 up edges on ch0.
        s0 = steps0;
        up_edges(0, 16);
        hold(10); @(negedge clk);
        check("fwd pos0",   32'(pos[0 +: W]), 32'd16);
        check("fwd steps",  32'(steps0 - s0), 32'd16);
        check("fwd dir0",   32'(dir[0]), 32'd1);
        check("fwd pos1",   32'(pos[W +: W]), 32'd0);

        // Inverted direction from zero.
        pulse_clr(0);
        dir_inv[0] = 1'b1;
        up_edges(0, 16);
        hold(10); @(negedge clk);
        check("inv pos0", 32'(pos[0 +: W]), 32'hFFF0);
        check("inv dir0", 32'(dir[0]), 32'd0);
        dir_inv[0] = 1'b0;
        pulse_clr(0);
        hold(5);

        // Wrap and exact latency: down edge 00->01 driven after edge t.
        @(posedge clk); #1 enc_b[0] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("lat before", 32'(pos[0 +: W]), 32'd0);
        @(posedge clk); @(negedge clk);
        check("lat at t+7", 32'(pos[0 +: W]), 32'hFFFF);
        check("lat step",   32'(step[0]), 32'd1);
        hold(10);
        set_ab(0, 2'b00);
        hold(5); @(negedge clk);
        check("wrap up", 32'(pos[0 +: W]), 32'd0);

        // Glitches on A.
        s0 = steps0;
        @(posedge clk); #1 enc_a[0] = 1'b1;
        repeat (3) @(posedge clk); #1 enc_a[0] = 1'b0;
        hold(12); @(negedge clk);
        check("glitch3 pos",   32'(pos[0 +: W]), 32'd0);
        check("glitch3 steps", 32'(steps0 - s0), 32'd0);
        @(posedge clk); #1 enc_a[0] = 1'b1;
        repeat (4) @(posedge clk); #1 enc_a[0] = 1'b0;
        hold(12); @(negedge clk);
        check("glitch4 pos",   32'(pos[0 +: W]), 32'd0);
        check("glitch4 steps", 32'(steps0 - s0), 32'd2);
        check("glitch4 err",   32'(err[0]), 32'd0);

        // Illegal 00->11, sticky error, then clear.
        set_ab(0, 2'b11);
        hold(3); @(negedge clk);
        check("illegal err", 32'(err[0]), 32'd1);
        check("illegal pos", 32'(pos[0 +: W]), 32'd0);
        up_edges(0, 2);
        hold(3); @(negedge clk);
        check("sticky err", 32'(err[0]), 32'd1);
        check("sticky pos", 32'(pos[0 +: W]), 32'd2);
        pulse_clr(0);
        @(negedge clk);
        check("clr err", 32'(err[0]), 32'd0);
        check("clr pos", 32'(pos[0 +: W]), 32'd0);

        // Simultaneous motion on both channels: ch0 up, ch1 down.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] n0, n1;
            n0 = up_next({enc_a[0], enc_b[0]});
            n1 = 2'b00;
            for (int k = 0; k < 4; k++) begin
                logic [1:0] kk;
                kk = 2'(k);
                if (up_next(kk) == {enc_a[1], enc_b[1]}) n1 = kk;
            end
            @(posedge clk); #1;
            enc_a = {n1[1], n0[1]};
            enc_b = {n1[0], n0[0]};
            hold(9);
        end
        hold(5); @(negedge clk);
        check("dual pos0", 32'(pos[0 +: W]), 32'd4);
        check("dual pos1", 32'(pos[W +: W]), 32'hFFFC);
        pulse_clr(0);

        // Index with zeroing.
        up_edges(0, 37);
        z_clr_en[0] = 1'b1;
        s0 = zvlds0;
        @(posedge clk); #1 enc_z[0] = 1'b1;
        hold(12); @(negedge clk);
        check("zclr zpos", 32'(zpos[0 +: W]), 32'd37);
        check("zclr pos",  32'(pos[0 +: W]), 32'd0);
        check("zclr vlds", 32'(zvlds0 - s0), 32'd1);
        @(posedge clk); #1 enc_z[0] = 1'b0;
        hold(12);
        check("zfall vlds", 32'(zvlds0 - s0), 32'd1);

        // Index without zeroing.
        z_clr_en[0] = 1'b0;
        up_edges(0, 37);
        @(posedge clk); #1 enc_z[0] = 1'b1;
        hold(12); @(negedge clk);
        check("zhold zpos", 32'(zpos[0 +: W]), 32'd37);
        check("zhold pos",  32'(pos[0 +: W]), 32'd37);
        check("zhold vlds", 32'(zvlds0 - s0), 32'd2);

        // Reset mid-rotation with AB parked at 11.
        while ({enc_a[0], enc_b[0]} != 2'b11) up_edges(0, 1);
        hold(5);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("async pos0", 32'(pos[0 +: W]), 32'd0);
        check("async zpos", 32'(zpos[0 +: W]), 32'd0);
        check("async dir",  32'(dir), 32'd0);
        hold(3);
        #1 rst = 1'b0;
        s0 = steps0;
        hold(20); @(negedge clk);
        check("rel steps", 32'(steps0 - s0), 32'd0);
        check("rel err",   32'(err[0]), 32'd0);
        up_edges(0, 1);
        hold(3); @(negedge clk);
        check("rel count", 32'(pos[0 +: W]), 32'd1);

        hold(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/quad_encoder_mc.md
Name: quad_encoder_mc

Overview:
- Multi-channel incremental (A/B/Z) quadrature encoder decoder.
- Per channel: synchronises and glitch-filters the raw pins, then decodes in x4 mode into a signed position counter.
- Latches position on index (Z) edges, optionally zeroing on index, and flags illegal transitions.
- Sits between the PMOD input pins and user logic/debug (LEDs, ILA); replaces the single-channel, count-less encoder front end.

Parameters:
- N_CH, 2, number of independent encoder channels (>=1).
- CNT_W, 32, position counter width in bits (>=2).
- SYNC_STAGES, 2, synchroniser flops per input pin (>=2).
- FILT_LEN, 8, consecutive stable cycles needed to accept a new pin level (>=1).

Ports:
- I_CLK_100MHZ  in   1            system clock, all logic on rising edge
- I_RST         in   1            asynchronous, active-high reset
- I_ENC_A       in   N_CH         raw A phase, bit i = channel i
- I_ENC_B       in   N_CH         raw B phase
- I_ENC_Z       in   N_CH         raw index
- I_Z_CLR_EN    in   N_CH         1 = index rising edge zeroes the position
- I_DIR_INV     in   N_CH         1 = invert count direction
- I_CNT_CLR     in   N_CH         synchronous per-channel clear, level-sensitive
- O_POS         out  N_CH*CNT_W   position, channel i at [i*CNT_W +: CNT_W], two's complement
- O_Z_POS       out  N_CH*CNT_W   position captured at last index edge
- O_Z_VLD       out  N_CH         1-cycle pulse when O_Z_POS updates
- O_STEP        out  N_CH         1-cycle pulse per accepted count
- O_DIR         out  N_CH         direction of last count, 1 = up
- O_ERR         out  N_CH         sticky illegal-transition flag

Behaviour:
- Reset: while I_RST=1 all outputs, sync chains, filters and counters are 0, asynchronously. Per-channel armed flag is 0.
- Sync: each of A/B/Z passes through SYNC_STAGES flops.
- Filter, per pin:
  - Per-pin counter increments while the synced level differs from the filtered level; it resets to 0 when they are equal.
  - When the counter reaches FILT_LEN-1 and the level still differs, the filtered level takes the synced level and the counter resets.
  - Net effect: a level must be stable for FILT_LEN cycles to be accepted.
- Arming: the first cycle after reset in which all three filters are idle (counter 0) loads prev_AB and prev_Z from the filtered values. No count, error or index event is produced, and the armed flag is set. A channel that is not armed ignores all events.
- Decode, each cycle when armed, comparing prev_AB to cur_AB:
  - Up sequence is 00->10->11->01->00 (A leads B). Reverse sequence is down.
  - I_DIR_INV swaps up and down.
  - Legal step: O_POS +/-1 modulo 2^CNT_W (0 - 1 = all-ones, max + 1 = 0). O_STEP pulses and O_DIR updates.
  - No change: nothing happens.
  - Both bits changed: no count, no O_STEP, O_ERR set to 1 (sticky).
  - prev_AB always updates to cur_AB.
- Latency: a clean raw edge at clock edge t changes O_POS / O_STEP at edge t + SYNC_STAGES + FILT_LEN + 1. With default parameters this is t+11.
- Index: a rising edge of filtered Z (prev_Z=0, cur_Z=1) sets O_Z_POS to the position value after this cycle's step is applied, and pulses O_Z_VLD.
  - If I_Z_CLR_EN=1, O_POS becomes 0 and any same-cycle step is discarded (O_STEP still pulses, O_DIR still updates).
  - Falling edges of Z have no effect.
- Priority per channel, highest first: I_RST, I_CNT_CLR, index clear, step.
- I_CNT_CLR=1: O_POS=0, O_ERR=0 and O_Z_POS=0. It does not suppress O_STEP/O_Z_VLD pulses or the O_DIR update. Filters and prev state keep running, so no spurious count occurs on release.
- Channels are fully independent; simultaneous events on different channels never interact.
- Reset mid-motion: everything returns to 0 immediately. After release the channel re-arms, and the current pin levels produce no step and no error.

Test Plan:
- Setup for all scenarios: N_CH=2, CNT_W=16, SYNC_STAGES=2, FILT_LEN=4; each level held >=10 cycles.
- Forward: ch0 driven 4 full up cycles (16 edges) -> O_POS ch0=16, 16 O_STEP pulses, O_DIR=1, ch1 O_POS=0. Repeating with I_DIR_INV[0]=1 -> 0xFFF0.
- Wrap and latency: from 0, one down edge at edge t -> O_POS=0xFFFF exactly at edge t+7. One up edge -> 0x0000.
- Glitch: 3-cycle pulse on A -> no change. 4-cycle pulse -> +1 then -1, 2 O_STEP pulses, O_ERR=0.
- Illegal: A and B toggled in the same cycle from 00 to 11 -> O_ERR[0]=1, O_POS unchanged, stays 1 across further legal steps. 1-cycle I_CNT_CLR -> O_ERR=0, O_POS=0.
- Index: O_POS=37, Z rising with I_Z_CLR_EN=1 -> O_Z_POS=37, 1-cycle O_Z_VLD, O_POS=0. Same with I_Z_CLR_EN=0 -> O_Z_POS=37, O_POS stays 37.
- Reset: I_RST pulsed mid-rotation with pins held at AB=11 -> all outputs 0 asynchronously. After release, no O_STEP and no O_ERR, and the next legal edge counts from 0.
